// File: rtl/cdc_wptr_full.sv
// rtl/cdc_wptr_full.sv - write-side pointer, Gray publish and full/level flags for a dual-clock FIFO
module cdc_wptr_full #(
    parameter int DLY         = 1,
    parameter int AW          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 12
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wr_en_i,
    input  logic [AW:0]   rptr_gray_i,
    output logic [AW-1:0] waddr_o,
    output logic [AW:0]   wptr_gray_o,
    output logic          full_o,
    output logic          almost_full_o,
    output logic [AW:0]   wr_cnt_o,
    output logic          overflow_o
);

    localparam logic [AW:0] AF_THR  = (AW+1)'(AF_LEVEL);
    // DLY affects simulation timing only; it folds to zero so it never alters state.
    localparam logic [AW:0] PTR_RST = (AW+1)'(DLY - DLY);

    logic [AW:0]                   wbin_q, wbin_d;
    logic [AW:0]                   wgray_q, wgray_d;
    logic                          full_q, full_d;
    logic                          af_q, af_d;
    logic [AW:0]                   cnt_q, cnt_d;
    logic                          ovf_q, ovf_d;
    logic [SYNC_STAGES-1:0][AW:0]  sync_q;
    logic [AW:0]                   rq;
    logic [AW:0]                   rbin;
    logic                          wr_acc;

    assign rq = sync_q[SYNC_STAGES-1];

    always_comb begin
        rbin = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin[i] = ^(rq >> i);
        end
    end

    // Decisions use the registered full flag, so a write racing a read at full is refused.
    always_comb begin
        wr_acc  = wr_en_i & ~full_q;
        wbin_d  = wbin_q + (AW+1)'(wr_acc);
        wgray_d = (wbin_d >> 1) ^ wbin_d;
        full_d  = (wgray_d == {~rq[AW:AW-1], rq[AW-2:0]});
        cnt_d   = wbin_d - rbin;
        af_d    = (cnt_d >= AF_THR);
        ovf_d   = wr_en_i & full_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rptr_gray_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wbin_q  <= PTR_RST;
            wgray_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            full_q  <= full_d;
            af_q    <= af_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign waddr_o       = wbin_q[AW-1:0];
    assign wptr_gray_o   = wgray_q;
    assign full_o        = full_q;
    assign almost_full_o = af_q;
    assign wr_cnt_o      = cnt_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_cdc_wptr_full.sv
// tb/tb_cdc_wptr_full.sv - vector table plus randomized reference-model bench for cdc_wptr_full
module tb_cdc_wptr_full;

    logic       clk_i = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n_i;
    logic       wr_en_i;
    logic [4:0] rd_bin;
    logic [4:0] rptr_gray_i;
    logic [3:0] waddr_o;
    logic [4:0] wptr_gray_o;
    logic       full_o;
    logic       almost_full_o;
    logic [4:0] wr_cnt_o;
    logic       overflow_o;

    assign rptr_gray_i = rd_bin ^ (rd_bin >> 1);

    cdc_wptr_full #(.DLY(1), .AW(4), .SYNC_STAGES(2), .AF_LEVEL(12)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .wr_en_i      (wr_en_i),
        .rptr_gray_i  (rptr_gray_i),
        .waddr_o      (waddr_o),
        .wptr_gray_o  (wptr_gray_o),
        .full_o       (full_o),
        .almost_full_o(almost_full_o),
        .wr_cnt_o     (wr_cnt_o),
        .overflow_o   (overflow_o)
    );

    always #5 if (clk_en) clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pointers as plain integers, fill level as modular distance,
    // the read pointer seen through a pure delay of two write edges.
    int  m_w, m_cnt;
    bit  m_full, m_af, m_ovf, m_acc;
    int  rd_q[$];

    function automatic void model_reset();
        m_w = 0; m_cnt = 0; m_full = 0; m_af = 0; m_ovf = 0; m_acc = 0;
        rd_q = {};
        rd_q.push_back(0);
        rd_q.push_back(0);
    endfunction

    function automatic void model_edge();
        int seen;
        m_acc = wr_en_i && !m_full;
        m_ovf = wr_en_i && m_full;
        m_w   = (m_w + int'(m_acc)) % 32;
        seen  = rd_q.pop_front();
        rd_q.push_back(int'(rd_bin));
        m_cnt  = (m_w - seen + 32) % 32;
        m_full = (m_cnt == 16);
        m_af   = (m_cnt >= 12);
    endfunction

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    task automatic check_model();
        check("m_waddr", int'(waddr_o), m_w % 16);
        check("m_gray", int'(wptr_gray_o), m_w ^ (m_w >> 1));
        check("m_cnt", int'(wr_cnt_o), m_cnt);
        check("m_full", int'(full_o), int'(m_full));
        check("m_af", int'(almost_full_o), int'(m_af));
        check("m_ovf", int'(overflow_o), int'(m_ovf));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_waddr"}, int'(waddr_o), 0);
        check({tag, "_gray"}, int'(wptr_gray_o), 0);
        check({tag, "_full"}, int'(full_o), 0);
        check({tag, "_af"}, int'(almost_full_o), 0);
        check({tag, "_cnt"}, int'(wr_cnt_o), 0);
        check({tag, "_ovf"}, int'(overflow_o), 0);
    endtask

    typedef struct {
        int wr; int rd;
        int waddr; int gray; int full; int af; int cnt; int ovf;
    } vec_t;

    vec_t tbl[$];
    int   gtab[16];
    int   prev_gray;
    int   seen_wrap;
    int   writes;
    int   cyc;

    initial begin
        gtab = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 24};
        for (int n = 1; n <= 16; n++)
            tbl.push_back('{1, 0, n % 16, gtab[n-1], int'(n == 16), int'(n >= 12), n, 0});
        for (int n = 0; n < 3; n++)
            tbl.push_back('{1, 0, 0, 24, 1, 1, 16, 1});
        tbl.push_back('{0, 1, 0, 24, 1, 1, 16, 0});
        tbl.push_back('{0, 1, 0, 24, 1, 1, 16, 0});
        tbl.push_back('{0, 1, 0, 24, 0, 1, 15, 0});

        // Reset with no clock running
        rst_n_i = 1'b1; wr_en_i = 1'b0; rd_bin = '0;
        model_reset();
        #2 rst_n_i = 1'b0;
        #1 check_zero("rst_noclk");
        clk_en = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_n_i = 1'b1;
        step(); step();
        check_zero("rst_rel");
        check_model();

        // Fill, overflow and release from the vector table
        foreach (tbl[k]) begin
            wr_en_i = tbl[k].wr[0];
            rd_bin  = 5'(tbl[k].rd);
            step();
            check($sformatf("t%0d_waddr", k), int'(waddr_o), tbl[k].waddr);
            check($sformatf("t%0d_gray", k), int'(wptr_gray_o), tbl[k].gray);
            check($sformatf("t%0d_full", k), int'(full_o), tbl[k].full);
            check($sformatf("t%0d_af", k), int'(almost_full_o), tbl[k].af);
            check($sformatf("t%0d_cnt", k), int'(wr_cnt_o), tbl[k].cnt);
            check($sformatf("t%0d_ovf", k), int'(overflow_o), tbl[k].ovf);
        end

        // Random traffic across the pointer wrap
        prev_gray = int'(wptr_gray_o);
        seen_wrap = 0;
        writes = 0;
        cyc = 0;
        while (writes < 100 && cyc < 2000) begin
            wr_en_i = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 1) == 1 && ((m_w - int'(rd_bin) + 32) % 32) > 0)
                rd_bin = rd_bin + 5'd1;
            step();
            cyc++;
            if (m_acc) writes++;
            check_model();
            if (prev_gray == 16 && int'(wptr_gray_o) == 0) seen_wrap = 1;
            prev_gray = int'(wptr_gray_o);
        end
        check("rand_writes_done", writes, 100);
        check("gray_wrap_seen", seen_wrap, 1);

        // Fill up, keep writing, then reset mid-cycle
        cyc = 0;
        wr_en_i = 1'b1;
        while (!m_full && cyc < 40) begin
            step();
            cyc++;
            check_model();
        end
        check("prefill_full", int'(full_o), 1);
        step();
        check_model();
        #2 rst_n_i = 1'b0;
        #1 check_zero("rst_mid");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        rd_bin  = '0;
        wr_en_i = 1'b1;
        model_reset();
        step();
        check("post_rst_waddr", int'(waddr_o), 1);
        check("post_rst_gray", int'(wptr_gray_o), 1);
        check_model();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
